// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and pipe_hazard_ctrl.
// The pipeline (master) reports hazard sources; the controller (slave) returns stall/bubble pairs and status.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic [4:0]       D_rs1_i;
  logic [4:0]       D_rs2_i;
  logic             D_use_rs1_i;
  logic             D_use_rs2_i;
  logic             E_load_i;
  logic             E_need_dstE_i;
  logic [4:0]       E_dstE_i;
  logic             E_redirect_i;
  logic             E_multi_start_i;
  logic             E_multi_done_i;
  logic             M_mem_wait_i;

  logic             F_stall_o;
  logic             F_bubble_o;
  logic             D_stall_o;
  logic             D_bubble_o;
  logic             E_stall_o;
  logic             E_bubble_o;
  logic             multi_busy_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    output E_load_i, E_need_dstE_i, E_dstE_i, E_redirect_i,
    output E_multi_start_i, E_multi_done_i, M_mem_wait_i,
    input  F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
    input  multi_busy_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    input  E_load_i, E_need_dstE_i, E_dstE_i, E_redirect_i,
    input  E_multi_start_i, E_multi_done_i, M_mem_wait_i,
    output F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
    output multi_busy_o, err_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, mem-wait and multi-cycle op sequencing
// with a watchdog, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W         = 32,
  parameter int MULTI_TIMEOUT = 64,
  parameter int TO_W          = 7
) (
  input  logic                clk_i,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t          state_reg;
  logic [TO_W-1:0] wdog_reg;
  logic            err_reg;

  logic [4:0]      d_rs [2];
  logic [1:0]      d_use;
  logic [1:0]      src_hit;
  logic            lu_hit;
  logic            in_multi;
  logic            ms_hit;
  logic            timeout_hit;

  logic            f_stall;
  logic            f_bubble;
  logic            d_stall;
  logic            d_bubble;
  logic            e_stall;
  logic            e_bubble;
  logic            flush_inc;
  logic [1:0]      cnt_inc;

  assign d_rs[0] = hz.D_rs1_i;
  assign d_rs[1] = hz.D_rs2_i;
  assign d_use   = {hz.D_use_rs2_i, hz.D_use_rs1_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = d_use[gi] && (d_rs[gi] == hz.E_dstE_i);
    end
  endgenerate

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_hit = hz.E_load_i && hz.E_need_dstE_i && (hz.E_dstE_i != 5'd0) && (|src_hit);

  assign in_multi    = (state_reg == ST_MULTI);
  assign ms_hit      = !hz.E_multi_done_i && ((!in_multi && hz.E_multi_start_i) || in_multi);
  assign timeout_hit = in_multi && !hz.E_multi_done_i && (wdog_reg == TO_W'(MULTI_TIMEOUT));

  always_comb begin
    f_stall   = 1'b0;
    f_bubble  = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_stall   = 1'b0;
    e_bubble  = 1'b0;
    flush_inc = 1'b0;
    if (!rst_n) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      e_bubble = 1'b1;
    end else if (hz.M_mem_wait_i) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
    end else if (ms_hit) begin
      f_stall  = 1'b1;
      e_bubble = 1'b1;
      // On timeout the stuck op is squashed out of decode_reg; fetch_reg keeps
      // holding so the instruction behind the op is not lost.
      if (timeout_hit) begin
        d_bubble = 1'b1;
      end else begin
        d_stall = 1'b1;
      end
    end else if (hz.E_redirect_i) begin
      f_bubble  = 1'b1;
      d_bubble  = 1'b1;
      flush_inc = 1'b1;
    end else if (lu_hit) begin
      f_stall  = 1'b1;
      d_bubble = 1'b1;
    end
  end

  assign hz.F_stall_o  = f_stall;
  assign hz.F_bubble_o = f_bubble;
  assign hz.D_stall_o  = d_stall;
  assign hz.D_bubble_o = d_bubble;
  assign hz.E_stall_o  = e_stall;
  assign hz.E_bubble_o = e_bubble;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      wdog_reg  <= '0;
      err_reg   <= 1'b0;
    end else if (!hz.M_mem_wait_i) begin
      case (state_reg)
        ST_RUN: begin
          if (hz.E_multi_start_i && !hz.E_multi_done_i) begin
            state_reg <= ST_MULTI;
            wdog_reg  <= TO_W'(1);
          end
        end
        ST_MULTI: begin
          if (hz.E_multi_done_i) begin
            state_reg <= ST_RUN;
            wdog_reg  <= '0;
          end else if (wdog_reg == TO_W'(MULTI_TIMEOUT)) begin
            state_reg <= ST_RUN;
            wdog_reg  <= '0;
            err_reg   <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + TO_W'(1);
          end
        end
        default: begin
          state_reg <= ST_RUN;
          wdog_reg  <= '0;
        end
      endcase
    end
  end

  assign hz.multi_busy_o = in_multi;
  assign hz.err_o        = err_reg;

  assign cnt_inc = {flush_inc, f_stall};

  // Slot 0 counts fetch-stall cycles, slot 1 counts accepted redirects.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign hz.stall_cnt_o = g_cnt[0].cnt_reg;
  assign hz.flush_cnt_o = g_cnt[1].cnt_reg;

  a_f_excl: assert property (@(posedge clk_i) disable iff (!rst_n) !(f_stall && f_bubble));
  a_d_excl: assert property (@(posedge clk_i) disable iff (!rst_n) !(d_stall && d_bubble));
  a_e_excl: assert property (@(posedge clk_i) disable iff (!rst_n) !(e_stall && e_bubble));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios with literal expectations,
// then randomized traffic checked every cycle against a priority-table model.
module tb_pipe_hazard_ctrl;

  localparam int     TB_CNT_W = 4;
  localparam int     TB_TO    = 4;
  localparam int     TB_TO_W  = 3;
  localparam longint CMAX     = (longint'(1) << TB_CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz_if ();

  pipe_hazard_ctrl #(
    .CNT_W(TB_CNT_W),
    .MULTI_TIMEOUT(TB_TO),
    .TO_W(TB_TO_W)
  ) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .hz(hz_if.slave)
  );

  always #5 clk_i = ~clk_i;

  int     total = 0;
  int     bad   = 0;
  // age = 0: no op in flight; age = k: k-th cycle the op has been waiting in MULTI
  int     age;
  bit     m_err;
  longint m_stall;
  longint m_flush;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    age     = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Returns {F_stall, F_bubble, D_stall, D_bubble, E_stall, E_bubble, redirect_accepted}
  function automatic logic [6:0] model_ctrl();
    bit lu, ms, tmo;
    if (!rst_n) return 7'b0101010;
    lu  = hz_if.E_load_i && hz_if.E_need_dstE_i && (hz_if.E_dstE_i != 0) &&
          ((hz_if.D_use_rs1_i && hz_if.D_rs1_i == hz_if.E_dstE_i) ||
           (hz_if.D_use_rs2_i && hz_if.D_rs2_i == hz_if.E_dstE_i));
    ms  = !hz_if.E_multi_done_i && (age != 0 || hz_if.E_multi_start_i);
    tmo = (age == TB_TO) && !hz_if.E_multi_done_i;
    if (hz_if.M_mem_wait_i) return 7'b1010100;
    if (ms && tmo)          return 7'b1001010;
    if (ms)                 return 7'b1010010;
    if (hz_if.E_redirect_i) return 7'b0101001;
    if (lu)                 return 7'b1001000;
    return 7'b0000000;
  endfunction

  function automatic void model_update();
    logic [6:0] c;
    c = model_ctrl();
    if (c[6]) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
    if (c[0]) m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
    if (!hz_if.M_mem_wait_i) begin
      if (age == 0) begin
        if (hz_if.E_multi_start_i && !hz_if.E_multi_done_i) age = 1;
      end else if (hz_if.E_multi_done_i) begin
        age = 0;
      end else if (age == TB_TO) begin
        m_err = 1'b1;
        age   = 0;
      end else begin
        age++;
      end
    end
  endfunction

  // Mid-cycle: compare every DUT output against the model, one line per cycle.
  task automatic settle();
    logic [6:0] c;
    @(negedge clk_i);
    if (!rst_n) model_reset();
    c = model_ctrl();
    chk("F_stall",   hz_if.F_stall_o,  c[6]);
    chk("F_bubble",  hz_if.F_bubble_o, c[5]);
    chk("D_stall",   hz_if.D_stall_o,  c[4]);
    chk("D_bubble",  hz_if.D_bubble_o, c[3]);
    chk("E_stall",   hz_if.E_stall_o,  c[2]);
    chk("E_bubble",  hz_if.E_bubble_o, c[1]);
    chk("busy",      hz_if.multi_busy_o, (age != 0) ? 1 : 0);
    chk("err",       hz_if.err_o,       m_err);
    chk("stall_cnt", hz_if.stall_cnt_o, m_stall);
    chk("flush_cnt", hz_if.flush_cnt_o, m_flush);
    $display("t=%0t rst_n=%b ctrl=%b%b%b%b%b%b busy=%b err=%b scnt=%0d fcnt=%0d", $time, rst_n,
             hz_if.F_stall_o, hz_if.F_bubble_o, hz_if.D_stall_o, hz_if.D_bubble_o,
             hz_if.E_stall_o, hz_if.E_bubble_o, hz_if.multi_busy_o, hz_if.err_o,
             hz_if.stall_cnt_o, hz_if.flush_cnt_o);
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_n) model_update();
    else       model_reset();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic set_idle();
    hz_if.D_rs1_i = 5'd0;  hz_if.D_rs2_i = 5'd0;
    hz_if.D_use_rs1_i = 1'b0;  hz_if.D_use_rs2_i = 1'b0;
    hz_if.E_load_i = 1'b0;  hz_if.E_need_dstE_i = 1'b0;  hz_if.E_dstE_i = 5'd0;
    hz_if.E_redirect_i = 1'b0;  hz_if.E_multi_start_i = 1'b0;
    hz_if.E_multi_done_i = 1'b0;  hz_if.M_mem_wait_i = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] dst);
    hz_if.E_load_i = 1'b1;  hz_if.E_need_dstE_i = 1'b1;  hz_if.E_dstE_i = dst;
    hz_if.D_rs1_i = dst;    hz_if.D_use_rs1_i = 1'b1;
  endtask

  initial begin
    model_reset();
    set_idle();

    // Reset state: bubbles forced, counters zero
    settle();
    chk("rst_fbubble", hz_if.F_bubble_o, 1);
    chk("rst_estall",  hz_if.E_stall_o, 0);
    chk("rst_scnt",    hz_if.stall_cnt_o, 0);
    advance();
    rst_n = 1'b1;
    settle();
    chk("idle_fbubble", hz_if.F_bubble_o, 0);
    advance();

    // Load-use on x5, then the same with x0
    set_lu(5'd5);
    settle();
    chk("lu_fstall", hz_if.F_stall_o, 1);
    chk("lu_dbubble", hz_if.D_bubble_o, 1);
    chk("lu_dstall", hz_if.D_stall_o, 0);
    chk("lu_scnt0", hz_if.stall_cnt_o, 0);
    advance();
    set_idle();
    settle();
    chk("lu_scnt1", hz_if.stall_cnt_o, 1);
    chk("lu_once", hz_if.F_stall_o, 0);
    advance();
    set_lu(5'd0);
    settle();
    chk("lu_x0", {hz_if.F_stall_o, hz_if.F_bubble_o, hz_if.D_stall_o,
                  hz_if.D_bubble_o, hz_if.E_stall_o, hz_if.E_bubble_o}, 0);
    advance();

    // Redirect beats load-use
    set_lu(5'd7);
    hz_if.E_redirect_i = 1'b1;
    settle();
    chk("rd_fbubble", hz_if.F_bubble_o, 1);
    chk("rd_dbubble", hz_if.D_bubble_o, 1);
    chk("rd_fstall", hz_if.F_stall_o, 0);
    chk("rd_fcnt0", hz_if.flush_cnt_o, 0);
    advance();
    set_idle();
    settle();
    chk("rd_fcnt1", hz_if.flush_cnt_o, 1);
    advance();

    // Five-cycle divide: done arrives on the fifth cycle
    hz_if.E_multi_start_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      hz_if.E_multi_done_i = (i == 5);
      settle();
      chk("div_busy", hz_if.multi_busy_o, (i >= 2) ? 1 : 0);
      chk("div_fstall", hz_if.F_stall_o, (i <= 4) ? 1 : 0);
      chk("div_ebubble", hz_if.E_bubble_o, (i <= 4) ? 1 : 0);
      advance();
    end
    set_idle();
    settle();
    chk("div_run", hz_if.multi_busy_o, 0);
    chk("div_scnt", hz_if.stall_cnt_o, 5);
    advance();

    // Mem wait for three cycles in the middle of a divide
    hz_if.E_multi_start_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      hz_if.M_mem_wait_i   = (i >= 3 && i <= 5);
      hz_if.E_multi_done_i = (i == 7);
      settle();
      if (i >= 3 && i <= 5) begin
        chk("mw_estall", hz_if.E_stall_o, 1);
        chk("mw_ebubble", hz_if.E_bubble_o, 0);
        chk("mw_busy", hz_if.multi_busy_o, 1);
      end
      advance();
    end
    set_idle();
    settle();
    chk("mw_scnt", hz_if.stall_cnt_o, 11);
    chk("mw_err", hz_if.err_o, 0);
    advance();

    // Watchdog timeout, done never arrives; stall counter also saturates here
    hz_if.E_multi_start_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      settle();
      if (i == 5) begin
        chk("to_dbubble", hz_if.D_bubble_o, 1);
        chk("to_ebubble", hz_if.E_bubble_o, 1);
        chk("to_dstall", hz_if.D_stall_o, 0);
        chk("to_err_pre", hz_if.err_o, 0);
      end
      advance();
    end
    set_idle();
    settle();
    chk("to_err", hz_if.err_o, 1);
    chk("to_run", hz_if.multi_busy_o, 0);
    chk("sat_scnt", hz_if.stall_cnt_o, 15);
    advance();
    set_lu(5'd3);
    step();
    set_idle();
    settle();
    chk("sat_hold", hz_if.stall_cnt_o, 15);
    chk("err_sticky", hz_if.err_o, 1);
    advance();

    // Randomized traffic with occasional async reset pulses
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_n                 = ($urandom_range(0, 99) != 0);
      hz_if.E_load_i        = $urandom_range(0, 1);
      hz_if.E_need_dstE_i   = ($urandom_range(0, 3) != 0);
      hz_if.E_dstE_i        = 5'($urandom_range(0, 3));
      hz_if.D_rs1_i         = 5'($urandom_range(0, 3));
      hz_if.D_rs2_i         = 5'($urandom_range(0, 3));
      hz_if.D_use_rs1_i     = $urandom_range(0, 1);
      hz_if.D_use_rs2_i     = $urandom_range(0, 1);
      hz_if.E_redirect_i    = ($urandom_range(0, 4) == 0);
      hz_if.E_multi_start_i = (age != 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      hz_if.E_multi_done_i  = ($urandom_range(0, 5) == 0);
      hz_if.M_mem_wait_i    = ($urandom_range(0, 6) == 0);
      step();
    end
    rst_n = 1'b1;
    set_idle();
    step();

    // Async reset in the middle of a multi-cycle op
    hz_if.E_multi_start_i = 1'b1;
    step();
    step();
    @(negedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_stalls", {hz_if.F_stall_o, hz_if.D_stall_o, hz_if.E_stall_o}, 0);
    chk("ar_bubbles", {hz_if.F_bubble_o, hz_if.D_bubble_o, hz_if.E_bubble_o}, 7);
    chk("ar_scnt", hz_if.stall_cnt_o, 0);
    chk("ar_fcnt", hz_if.flush_cnt_o, 0);
    chk("ar_busy", hz_if.multi_busy_o, 0);
    chk("ar_err", hz_if.err_o, 0);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    set_idle();
    settle();
    chk("ar_post", {hz_if.F_stall_o, hz_if.F_bubble_o, hz_if.D_stall_o,
                    hz_if.D_bubble_o, hz_if.E_stall_o, hz_if.E_bubble_o}, 0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
